// File: rtl/multi_ch_clk_divider_if.sv
// multi_ch_clk_divider_if: shared configuration write bus for the divider channels
//   cfg_we : one-cycle write strobe
//   cfg_ch : target channel index (indices >= N_CH are ignored by the divider)
//   cfg_t  : terminal count T, period = T+1 clk cycles
//   cfg_h  : high time H in clk cycles
interface multi_ch_clk_divider_if #(
    parameter int CNT_W = 26
);
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_t;
    logic [CNT_W-1:0] cfg_h;
    modport master (output cfg_we, cfg_ch, cfg_t, cfg_h);
    modport slave  (input  cfg_we, cfg_ch, cfg_t, cfg_h);
endinterface

// File: rtl/multi_ch_clk_divider.sv
// multi_ch_clk_divider: N_CH independent programmable clock dividers with double-buffered config
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   ch_en       : per-channel enable
//   cfg         : config write bus (slave side)
//   sync_in     : phase-align request, honoured only when PHASE_SYNC_EN is defined
//   clk_out     : registered divided clocks
//   tick        : one-cycle pulse in the first cycle of each period
//   cfg_pending : shadow written but not yet applied
// Optional feature macro: PHASE_SYNC_EN
module multi_ch_clk_divider #(
    parameter int          N_CH  = 4,
    parameter int          CNT_W = 26,
    parameter int unsigned DEF_T = 59999999,
    parameter int unsigned DEF_H = 30000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CH-1:0]              ch_en,
    multi_ch_clk_divider_if.slave        cfg,
    input  logic                         sync_in,
    output logic [N_CH-1:0]              clk_out,
    output logic [N_CH-1:0]              tick,
    output logic [N_CH-1:0]              cfg_pending
);
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] sh_t_q [N_CH];
    logic [CNT_W-1:0] sh_t_d [N_CH];
    logic [CNT_W-1:0] sh_h_q [N_CH];
    logic [CNT_W-1:0] sh_h_d [N_CH];
    logic [CNT_W-1:0] act_t_q [N_CH];
    logic [CNT_W-1:0] act_t_d [N_CH];
    logic [CNT_W-1:0] act_h_q [N_CH];
    logic [CNT_W-1:0] act_h_d [N_CH];
    logic [N_CH-1:0]  run_q, run_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  clk_out_q, clk_out_d;
    logic [N_CH-1:0]  tick_q, tick_d;
    logic [N_CH-1:0]  wr, apply, sync_go;

`ifdef PHASE_SYNC_EN
    assign sync_go = ch_en & {N_CH{sync_in}};
`else
    logic unused_sync_in;
    assign unused_sync_in = sync_in;
    assign sync_go        = '0;
`endif

    // run_q remembers that the channel was enabled on the previous edge, so the
    // first enabled cycle always starts a fresh period at cnt=0.
    // A boundary (disabled, first enabled cycle, terminal count, sync) reloads
    // active from the old shadow; a same-cycle write lands in shadow afterwards
    // and keeps cfg_pending set. ">=" makes an out-of-range count wrap to 0.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr[i]        = cfg.cfg_we && (cfg.cfg_ch == 3'(i));
            apply[i]     = !ch_en[i] || !run_q[i] || (cnt_q[i] >= act_t_q[i]) || sync_go[i];
            cnt_d[i]     = apply[i] ? '0 : cnt_q[i] + CNT_W'(1);
            act_t_d[i]   = apply[i] ? sh_t_q[i] : act_t_q[i];
            act_h_d[i]   = apply[i] ? sh_h_q[i] : act_h_q[i];
            sh_t_d[i]    = wr[i] ? cfg.cfg_t : sh_t_q[i];
            sh_h_d[i]    = wr[i] ? cfg.cfg_h : sh_h_q[i];
            pend_d[i]    = wr[i] || (!apply[i] && pend_q[i]);
            run_d[i]     = ch_en[i];
            clk_out_d[i] = ch_en[i] && (cnt_d[i] < act_h_d[i]);
            tick_d[i]    = ch_en[i] && (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]   <= '0;
                sh_t_q[i]  <= CNT_W'(DEF_T);
                sh_h_q[i]  <= CNT_W'(DEF_H);
                act_t_q[i] <= CNT_W'(DEF_T);
                act_h_q[i] <= CNT_W'(DEF_H);
            end
            run_q     <= '0;
            pend_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                sh_t_q[i]  <= sh_t_d[i];
                sh_h_q[i]  <= sh_h_d[i];
                act_t_q[i] <= act_t_d[i];
                act_h_q[i] <= act_h_d[i];
            end
            run_q     <= run_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign cfg_pending = pend_q;
endmodule

// File: tb/tb_multi_ch_clk_divider.sv
// tb_multi_ch_clk_divider: directed + randomized checks against a period/phase reference model
module tb_multi_ch_clk_divider;
    localparam int N_CH  = 4;
    localparam int CNT_W = 26;
    localparam int DEF_T = 59999999;
    localparam int DEF_H = 30000000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] ch_en = '0;
    logic            sync_in = 1'b0;
    logic [N_CH-1:0] clk_out, tick, cfg_pending;

    multi_ch_clk_divider_if #(.CNT_W(CNT_W)) cfg();

    multi_ch_clk_divider #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_T(DEF_T), .DEF_H(DEF_H)) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .cfg(cfg.slave), .sync_in(sync_in),
        .clk_out(clk_out), .tick(tick), .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    // Reference: each channel has a shadow setting, an active setting and its
    // phase (cycles elapsed in the current period).
    int        sh_t [N_CH], sh_h [N_CH], act_t [N_CH], act_h [N_CH], phase [N_CH];
    bit        was_on [N_CH], pend [N_CH];
    logic [N_CH-1:0] e_clk, e_tick, e_pend;
    int checks = 0, errors = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            sh_t[i] = DEF_T; sh_h[i] = DEF_H; act_t[i] = DEF_T; act_h[i] = DEF_H;
            phase[i] = 0; was_on[i] = 0; pend[i] = 0;
        end
        e_clk = '0; e_tick = '0; e_pend = '0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < N_CH; i++) begin
            bit on = ch_en[i];
            bit sy = 0;
            bit new_period;
`ifdef PHASE_SYNC_EN
            sy = on && sync_in;
`endif
            new_period = !on || !was_on[i] || sy || phase[i] >= act_t[i];
            if (new_period) begin
                phase[i] = 0;
                act_t[i] = sh_t[i];
                act_h[i] = sh_h[i];
                pend[i]  = 0;
            end else phase[i]++;
            was_on[i] = on;
            if (cfg.cfg_we && int'(cfg.cfg_ch) == i) begin
                sh_t[i] = int'(cfg.cfg_t);
                sh_h[i] = int'(cfg.cfg_h);
                pend[i] = 1;
            end
            e_clk[i]  = on && (phase[i] < act_h[i]);
            e_tick[i] = on && (phase[i] == 0);
            e_pend[i] = pend[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("clk_out", 32'(clk_out), 32'(e_clk));
        chk("tick", 32'(tick), 32'(e_tick));
        chk("cfg_pending", 32'(cfg_pending), 32'(e_pend));
    endtask

    task automatic write(input int ch, input int t, input int h);
        cfg.cfg_we = 1'b1;
        cfg.cfg_ch = 3'(ch);
        cfg.cfg_t  = CNT_W'(t);
        cfg.cfg_h  = CNT_W'(h);
        step();
        cfg.cfg_we = 1'b0;
    endtask

    initial begin
        int highs, ticks;
        cfg.cfg_we = 1'b0; cfg.cfg_ch = '0; cfg.cfg_t = '0; cfg.cfg_h = '0;
        model_reset();
        #12;
        chk("reset_clk_out", 32'(clk_out), 0);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_pending", 32'(cfg_pending), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ch0 T=9 H=5 written while disabled, then enabled
        write(0, 9, 5);
        step();
        chk("ch0_pending_cleared", 32'(cfg_pending[0]), 0);
        ch_en = 4'b0001;
        highs = 0; ticks = 0;
        repeat (20) begin
            step();
            highs += int'(clk_out[0]);
            ticks += int'(tick[0]);
        end
        chk("ch0_high_cycles", highs, 10);
        chk("ch0_ticks", ticks, 2);

        // reprogram mid-period at cnt=4
        for (int k = 0; k < 20 && phase[0] != 3; k++) step();
        write(0, 3, 1);
        chk("ch0_pending_set", 32'(cfg_pending[0]), 1);
        repeat (20) step();

        // ch1 H=0 then H>T, and an out-of-range cfg_ch
        write(1, 9, 0);
        step();
        ch_en = 4'b0011;
        repeat (15) step();
        write(1, 9, 12);
        repeat (25) step();
        write(6, 2, 1);
        repeat (3) step();

        // ch2 T=0 H=1 with an enable drop
        write(2, 0, 1);
        step();
        ch_en = 4'b0111;
        repeat (5) step();
        ch_en[2] = 1'b0;
        repeat (4) step();
        ch_en[2] = 1'b1;
        step();
        chk("ch2_reenable_tick", 32'(tick[2]), 1);
        chk("ch2_reenable_clk", 32'(clk_out[2]), 1);

        // write landing on terminal count
        write(0, 4, 2);
        for (int k = 0; k < 20 && phase[0] != 3; k++) step();
        write(0, 7, 3);
        repeat (25) step();

        // phase alignment
        ch_en = '0;
        write(0, 4, 2);
        write(1, 6, 3);
        ch_en = 4'b0001;
        repeat (3) step();
        ch_en = 4'b0011;
        repeat (5) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
`ifdef PHASE_SYNC_EN
        chk("sync_ticks", 32'(tick[1:0]), 3);
`endif
        repeat (10) step();

        // randomized traffic
        ch_en = 4'b1111;
        repeat (2000) begin
            for (int i = 0; i < N_CH; i++) if ($urandom_range(0, 31) == 0) ch_en[i] = ~ch_en[i];
            sync_in    = ($urandom_range(0, 39) == 0);
            cfg.cfg_we = ($urandom_range(0, 3) == 0);
            cfg.cfg_ch = 3'($urandom_range(0, 7));
            cfg.cfg_t  = CNT_W'($urandom_range(0, 12));
            cfg.cfg_h  = CNT_W'($urandom_range(0, 15));
            step();
        end
        cfg.cfg_we = 1'b0;
        sync_in = 1'b0;

        // reset asserted mid-period
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_clk_out", 32'(clk_out), 0);
        chk("midreset_tick", 32'(tick), 0);
        chk("midreset_pending", 32'(cfg_pending), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
